// File: rtl/dwa_element_selector.sv
// ---------------------------------------------------------------------------
// dwa_element_selector
//
// Quantizes signed samples from the noise-shaping filter to a unit-element
// count and drives a rotating thermometer enable vector onto the unit-element
// DAC array using data-weighted averaging (DWA). Consecutive patterns start
// where the previous one ended, so every element is used equally often and
// element mismatch is first-order shaped.
//
// Ports:
//   clk        rising-edge system clock
//   reset      synchronous, active-low reset
//   x_in       signed sample from the shaping filter (WIDTH bits)
//   in_valid   x_in is valid
//   in_ready   block accepts x_in this cycle
//   elem_en    unit-element enables, bit i drives element i (N_ELEM bits)
//   out_valid  elem_en holds a new pattern
//   out_ready  element driver consumes the pattern this cycle
//   ptr        rotation pointer: start index of the next pattern
//   code_out   element count of the pattern currently on elem_en
//   bypass     (only with DWA_BYPASS_EN) plain thermometer from element 0,
//              rotation pointer frozen
//
// Optional feature macro: DWA_BYPASS_EN
//   undefined (default): always DWA, no bypass port.
//   defined: adds the bypass input, sampled in the LOAD cycle.
//
// Flow: IDLE --accept--> LOAD --(2nd edge)--> EMIT --handshake--> IDLE, or
// straight back to LOAD when a new sample arrives in the handshake cycle.
// ---------------------------------------------------------------------------
module dwa_element_selector #(
    parameter int WIDTH  = 16,
    parameter int N_ELEM = 16,
    parameter int SHIFT  = 8,
    parameter int PTR_W  = $clog2(N_ELEM)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [N_ELEM-1:0]       elem_en,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [PTR_W-1:0]        ptr,
    output logic [PTR_W:0]          code_out
`ifdef DWA_BYPASS_EN
    ,
    input  logic                    bypass
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_EMIT = 2'd2
    } state_t;

    // Mid-scale offset and full-scale limit, both at the quantizer width.
    localparam logic signed [WIDTH:0] HALF_C      = (WIDTH+1)'(N_ELEM / 2);
    localparam logic signed [WIDTH:0] FULL_C      = (WIDTH+1)'(N_ELEM);
    localparam logic [PTR_W:0]        FULL_CODE_C = (PTR_W+1)'(N_ELEM);

    // Thermometer of 'code' ones rotated to begin at bit 'start'. Bit i is set
    // when its distance from start (mod N_ELEM) is below code; a full-scale
    // code therefore lights every element.
    function automatic logic [N_ELEM-1:0] rot_therm(
        input logic [PTR_W:0]   code,
        input logic [PTR_W-1:0] start
    );
        logic [N_ELEM-1:0] m;
        logic [PTR_W-1:0]  off;
        m = {N_ELEM{1'b0}};
        for (int i = 0; i < N_ELEM; i++) begin
            off  = PTR_W'(i) - start;
            m[i] = ({1'b0, off} < code);
        end
        return m;
    endfunction

    state_t              state_r;
    logic [PTR_W:0]      code_r;      // code latched on accept
    logic [N_ELEM-1:0]   elem_en_r;
    logic [PTR_W:0]      code_out_r;
    logic                out_valid_r;
    logic [PTR_W-1:0]    ptr_r;
    logic                hold_ptr_s;  // pattern on elem_en must not advance ptr

    logic signed [WIDTH:0] x_ext_s;
    logic signed [WIDTH:0] q_s;
    logic [PTR_W:0]        code_s;
    logic [PTR_W-1:0]      start_s;
    logic [N_ELEM-1:0]     mask_s;
    logic                  in_ready_s;

`ifdef DWA_BYPASS_EN
    logic bypass_r;   // bypass value captured with the current pattern

    // Bypassed patterns start at element 0 and leave the pointer alone.
    always_comb begin
        hold_ptr_s = bypass_r;
        if (bypass) begin
            start_s = {PTR_W{1'b0}};
        end else begin
            start_s = ptr_r;
        end
    end

    // Capture bypass together with the pattern it shaped.
    always_ff @(posedge clk) begin
        if (!reset) begin
            bypass_r <= 1'b0;
        end else if (state_r == ST_LOAD) begin
            bypass_r <= bypass;
        end
    end
`else
    // Without bypass every pattern starts at the rotation pointer.
    always_comb begin
        hold_ptr_s = 1'b0;
        start_s    = ptr_r;
    end
`endif

    // Quantizer: scale, re-centre on mid-scale, then clamp to 0..N_ELEM.
    // One extra bit keeps the offset addition from overflowing.
    always_comb begin
        x_ext_s = {x_in[WIDTH-1], x_in};
        q_s     = (x_ext_s >>> SHIFT) + HALF_C;
        if (q_s[WIDTH]) begin
            code_s = {(PTR_W+1){1'b0}};
        end else if (q_s > FULL_C) begin
            code_s = FULL_CODE_C;
        end else begin
            code_s = q_s[PTR_W:0];
        end
    end

    // Rotated mask for the latched code.
    always_comb begin
        mask_s = rot_therm(code_r, start_s);
    end

    // Ready: always in IDLE, never in LOAD, and in EMIT only when the current
    // pattern is being consumed. Forced low while reset is asserted.
    always_comb begin
        case (state_r)
            ST_IDLE: in_ready_s = 1'b1;
            ST_LOAD: in_ready_s = 1'b0;
            ST_EMIT: in_ready_s = out_ready;
            default: in_ready_s = 1'b0;
        endcase
        if (!reset) begin
            in_ready_s = 1'b0;
        end else begin
            in_ready_s = in_ready_s;
        end
    end

    // Control FSM and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            code_r      <= {(PTR_W+1){1'b0}};
            elem_en_r   <= {N_ELEM{1'b0}};
            code_out_r  <= {(PTR_W+1){1'b0}};
            out_valid_r <= 1'b0;
            ptr_r       <= {PTR_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        code_r  <= code_s;
                        state_r <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    elem_en_r   <= mask_s;
                    code_out_r  <= code_r;
                    out_valid_r <= 1'b1;
                    state_r     <= ST_EMIT;
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        // Low PTR_W bits of the sum give the mod-N_ELEM
                        // advance; full-scale and zero codes leave ptr as is.
                        if (!hold_ptr_s) begin
                            ptr_r <= ptr_r + code_out_r[PTR_W-1:0];
                        end
                        // Pattern consumed: stale until the next LOAD.
                        out_valid_r <= 1'b0;
                        if (in_valid) begin
                            code_r  <= code_s;
                            state_r <= ST_LOAD;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_s;
    assign elem_en   = elem_en_r;
    assign out_valid = out_valid_r;
    assign ptr       = ptr_r;
    assign code_out  = code_out_r;

endmodule

// File: tb/tb_dwa_element_selector.sv
// ---------------------------------------------------------------------------
// Self-checking bench for dwa_element_selector (WIDTH=16, N_ELEM=16, SHIFT=8).
// Expected codes, masks and pointer values come from a behavioural model:
// integer arithmetic for the quantizer, and a mask built by lighting elements
// ptr, ptr+1, ... (mod 16) one at a time.
// ---------------------------------------------------------------------------
module tb_dwa_element_selector;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] x_in;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] elem_en;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  ptr;
    logic [4:0]  code_out;
`ifdef DWA_BYPASS_EN
    logic        bypass = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;

    // Model state.
    int          m_ptr;
    int          m_code;
    logic [15:0] m_mask;
    bit          m_emit;

    always #5 clk = ~clk;

    dwa_element_selector #(
        .WIDTH (16),
        .N_ELEM(16),
        .SHIFT (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .x_in     (x_in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .elem_en  (elem_en),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .ptr      (ptr),
        .code_out (code_out)
`ifdef DWA_BYPASS_EN
        ,
        .bypass   (bypass)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int model_code(input logic [15:0] x);
        int xi;
        int q;
        xi = int'($signed(x));
        q  = (xi >>> 8) + 8;
        if (q < 0) return 0;
        if (q > 16) return 16;
        return q;
    endfunction

    function automatic logic [15:0] model_mask(input int code, input int p);
        logic [15:0] m;
        m = 16'h0000;
        for (int k = 0; k < code; k++) m[(p + k) % 16] = 1'b1;
        return m;
    endfunction

    // Offer x (from IDLE, or from EMIT as a back-to-back handshake), then
    // follow it through LOAD into EMIT. Called #1 after a rising edge.
    task automatic accept(input logic [15:0] x);
        x_in      = x;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check("acc_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        if (m_emit) m_ptr = (m_ptr + m_code) % 16;
        m_code = model_code(x);
        m_mask = model_mask(m_code, m_ptr);
        m_emit = 1'b1;
        check("load_out_valid", out_valid, 0);
        check("load_in_ready", in_ready, 0);
        check("load_ptr", ptr, m_ptr);
        @(posedge clk); #1;
        check("emit_out_valid", out_valid, 1);
        check("emit_elem_en", elem_en, m_mask);
        check("emit_code_out", code_out, m_code);
        check("emit_ptr", ptr, m_ptr);
    endtask

    // Stall the driver for n cycles in EMIT.
    task automatic stall(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            check("stall_out_valid", out_valid, 1);
            check("stall_elem_en", elem_en, m_mask);
            check("stall_code_out", code_out, m_code);
            check("stall_ptr", ptr, m_ptr);
            check("stall_in_ready", in_ready, 0);
        end
    endtask

    // Stall, then consume the pattern with no new sample waiting.
    task automatic release_pat(input int n);
        stall(n);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        m_ptr  = (m_ptr + m_code) % 16;
        m_emit = 1'b0;
        check("rel_out_valid", out_valid, 0);
        check("rel_ptr", ptr, m_ptr);
        check("rel_elem_en_kept", elem_en, m_mask);
        check("rel_in_ready", in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] x;
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x_in      = 16'h0000;
        m_ptr     = 0;
        m_code    = 0;
        m_mask    = 16'h0000;
        m_emit    = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_elem_en", elem_en, 16'h0000);
        check("rst_ptr", ptr, 0);
        check("rst_code_out", code_out, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("idle_in_ready", in_ready, 1);

        // Directed walk through the pointer rotation, wrap and saturation.
        accept(16'h0000);
        check("tp_mask_00ff", elem_en, 16'h00FF);
        check("tp_code_8", code_out, 8);
        release_pat(0);
        check("tp_ptr_8", ptr, 8);
        accept(16'h0000);
        check("tp_mask_ff00", elem_en, 16'hFF00);
        stall(5);
        accept(16'd1024);                       // back-to-back after backpressure
        check("tp_ptr_0", ptr, 0);
        check("tp_mask_0fff", elem_en, 16'h0FFF);
        check("tp_code_12", code_out, 12);
        release_pat(0);
        check("tp_ptr_12", ptr, 12);
        accept(16'hFC00);                       // -1024
        check("tp_mask_f000", elem_en, 16'hF000);
        release_pat(1);
        check("tp_ptr_back_0", ptr, 0);
        accept(16'd1024);
        release_pat(0);
        accept(16'hFE00);                       // -512 from ptr 12
        check("tp_mask_f003", elem_en, 16'hF003);
        release_pat(0);
        check("tp_ptr_2", ptr, 2);
        accept(16'h7FFF);
        check("tp_mask_ffff", elem_en, 16'hFFFF);
        check("tp_code_16", code_out, 16);
        release_pat(0);
        check("tp_ptr_sat_hi", ptr, 2);
        accept(16'h8000);
        check("tp_mask_0000", elem_en, 16'h0000);
        release_pat(0);
        check("tp_ptr_sat_lo", ptr, 2);

        // Randomized traffic against the model.
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) x = 16'($urandom);
            else x = 16'($urandom_range(0, 6143)) - 16'd3072;
            accept(x);
            if ($urandom_range(0, 2) != 0) release_pat($urandom_range(0, 3));
            else stall($urandom_range(0, 2));
        end
        if (m_emit) release_pat(0);

        // Reset while a pattern is held in EMIT.
        accept(16'd1024);
        stall(1);
        reset = 1'b0;
        #1;
        check("mid_rst_in_ready", in_ready, 0);
        @(posedge clk); #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_elem_en", elem_en, 16'h0000);
        check("mid_rst_ptr", ptr, 0);
        reset  = 1'b1;
        m_ptr  = 0;
        m_emit = 1'b0;
        accept(16'h0000);
        check("post_rst_mask", elem_en, 16'h00FF);
        release_pat(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dwa_element_selector.md
Name: dwa_element_selector

Overview:
- Consumer end of the noise-shaping path in the DEM-DAC. It accepts signed filtered samples from the notch/noise-shaping stage and quantizes each one to a unit-element count.
- It drives a rotating thermometer enable vector onto the unit-element DAC array using data-weighted averaging (DWA), so element mismatch is first-order shaped.
- It sits between the shaping filter output and the analog unit-element drivers, with valid/ready on both sides.

Parameters:
- WIDTH, 16, input sample width (signed two's complement)
- N_ELEM, 16, number of unit elements; power of two, minimum 4
- SHIFT, 8, arithmetic right shift applied to the sample before quantization
- PTR_W, $clog2(N_ELEM), rotation pointer width (derived; do not override)

Ports:
- clk  in  1  system clock; all logic is rising-edge
- reset  in  1  synchronous, active-low reset
- x_in  in  WIDTH  signed sample from the shaping filter
- in_valid  in  1  x_in is valid
- in_ready  out  1  block can accept x_in this cycle
- elem_en  out  N_ELEM  unit-element enables; bit i drives element i
- out_valid  out  1  elem_en holds a new pattern
- out_ready  in  1  element driver consumes the pattern this cycle
- ptr  out  PTR_W  current rotation pointer, i.e. the start index for the next pattern
- code_out  out  PTR_W+1  element count for the pattern currently on elem_en

Behaviour:
- Reset (reset==0 at a clk edge): state=IDLE, elem_en=0, out_valid=0, ptr=0, code_out=0, in_ready=0 during the reset cycle. Reset mid-transaction drops any pending sample or pattern without emitting it.
- Quantization:
  - q = (x_in >>> SHIFT) + N_ELEM/2, computed at WIDTH+1 bits signed.
  - code = 0 if q<0; N_ELEM if q>N_ELEM; otherwise q.
  - code is latched on accept.
- States:
  - IDLE: in_ready=1. On in_valid, latch code and go to LOAD.
  - LOAD: in_ready=0. Build the mask, register elem_en/code_out, set out_valid=1, go to EMIT.
  - EMIT: out_valid=1, elem_en and code_out held stable. On out_ready, update ptr. If in_valid is also high in that cycle (in_ready=out_ready in EMIT), latch the new code and go to LOAD; otherwise clear out_valid and go to IDLE.
- Latency: accept edge to out_valid=1 is 2 clk edges. Sustained throughput is 1 sample per 2 cycles with out_ready held high.
- Mask: bits ptr, ptr+1, ..., ptr+code-1 (mod N_ELEM) are set; all other bits are 0.
  - Wrap-around past bit N_ELEM-1 continues at bit 0.
  - code=0 gives elem_en=0.
  - code=N_ELEM gives all ones.
- Pointer update on the EMIT handshake: ptr <= (ptr + code) mod N_ELEM. code=N_ELEM and code=0 both leave ptr unchanged.
- ptr changes only on the EMIT handshake, never in LOAD or IDLE.
- out_ready high while out_valid=0 has no effect.
- elem_en keeps its last pattern in IDLE. out_valid=0 marks it stale.

Optional Feature:
- Macro DWA_BYPASS_EN.
- When defined:
  - Adds input port bypass (1 bit).
  - When bypass=1 at the LOAD cycle, the mask starts at bit 0 (plain thermometer, elements 0..code-1) and ptr is not updated at the handshake.
  - bypass=0 gives normal DWA.
- When undefined: no bypass port; behaviour is always DWA.

Test Plan:
- Reset, then x_in=0 with in_valid: elem_en=16'h00FF, code_out=8, out_valid rises 2 edges after accept. After handshake ptr=8. A second x_in=0 gives elem_en=16'hFF00, and after handshake ptr=0.
- From ptr=0, x_in=1024 gives code 12, elem_en=16'h0FFF, ptr then 12. Next x_in=-1024 gives code 4, elem_en=16'hF000, ptr then 0.
- Wrap: from ptr=12, x_in=-512 gives code 6, elem_en=16'hF003, ptr then 2.
- Saturation:
  - x_in=32767 gives code 16, elem_en=16'hFFFF, ptr unchanged.
  - x_in=-32768 gives code 0, elem_en=16'h0000, ptr unchanged.
- Backpressure: hold out_ready=0 for 5 cycles in EMIT. elem_en, code_out and ptr stay stable and in_ready=0. Releasing out_ready while in_valid=1 accepts the next sample in the same cycle.
- Reset asserted during EMIT: next edge out_valid=0, elem_en=0, ptr=0. The first post-reset x_in=0 gives 16'h00FF.
